// File: rtl/noc_msg_packetizer.sv
// Tile transmit stage: turns a (dst, len) command plus a raw payload stream into
// one framed NoC packet (header word + len payload words, TLAST from own count).
module noc_msg_packetizer #(
  parameter int          BW      = 32,
  parameter int          BWB     = BW / 8,
  parameter int          XY_SZ   = 3,
  parameter int          LEN_W   = 12,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input  logic               clk_line,
  input  logic               clk_line_rst_high,
  input  logic [2*XY_SZ-1:0] HsrcId,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2*XY_SZ-1:0] cmd_dst,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               pay_TVALID,
  input  logic [BW-1:0]      pay_TDATA,
  input  logic [BWB-1:0]     pay_TKEEP,
  input  logic               pay_TLAST,
  output logic               pay_TREADY,
  output logic               out_TVALID,
  output logic [BW-1:0]      out_TDATA,
  output logic [BWB-1:0]     out_TKEEP,
  output logic               out_TLAST,
  input  logic               out_TREADY,
  output logic               busy,
  input  logic               err_clr,
  output logic               err_last_mismatch,
  output logic [15:0]        pkt_count
);

  typedef enum logic {IDLE, PAYLOAD} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic             vld_q;
  logic [BW-1:0]    data_q;
  logic [BWB-1:0]   keep_q;
  logic             last_q;
  logic             err_q;
  logic [15:0]      cnt_q;

  logic adv;
  logic last_word;
  logic pay_fire;
  logic err_d;

  // Header: dst in the low field, source above it, length at bit 16, tag on top.
  function automatic logic [BW-1:0] build_hdr(input logic [2*XY_SZ-1:0] dst,
                                               input logic [2*XY_SZ-1:0] src,
                                               input logic [LEN_W-1:0]   len);
    logic [BW-1:0] h;
    h                      = '0;
    h[2*XY_SZ-1:0]         = dst;
    h[4*XY_SZ-1:2*XY_SZ]   = src;
    h[16+LEN_W-1:16]       = len;
    h[31:28]               = HDR_TAG;
    return h;
  endfunction

  assign adv        = !vld_q || out_TREADY;
  assign last_word  = (rem_q == LEN_W'(1));
  assign cmd_ready  = (state_q == IDLE) && adv;
  assign pay_TREADY = (state_q == PAYLOAD) && adv;
  assign pay_fire   = pay_TVALID && pay_TREADY;

  // A framing error seen in the same cycle as a clear must survive.
  always_comb begin
    err_d = err_q;
    if (err_clr)
      err_d = 1'b0;
    if (pay_fire && (pay_TLAST != last_word))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      state_q <= IDLE;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (adv) begin
        vld_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (cmd_valid) begin
              vld_q  <= 1'b1;
              data_q <= build_hdr(cmd_dst, HsrcId, cmd_len);
              keep_q <= '1;
              last_q <= (cmd_len == '0);
              if (cmd_len != '0) begin
                rem_q   <= cmd_len;
                state_q <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (pay_TVALID) begin
              vld_q  <= 1'b1;
              data_q <= pay_TDATA;
              keep_q <= pay_TKEEP;
              last_q <= last_word;
              rem_q  <= rem_q - LEN_W'(1);
              if (last_word)
                state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      err_q <= err_d;
      if (vld_q && out_TREADY && last_q)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_TVALID        = vld_q;
  assign out_TDATA         = data_q;
  assign out_TKEEP         = keep_q;
  assign out_TLAST         = last_q;
  assign busy              = (state_q == PAYLOAD) || vld_q;
  assign err_last_mismatch = err_q;
  assign pkt_count         = cnt_q;

endmodule

// File: doc/noc_msg_packetizer.md
Name: noc_msg_packetizer

Overview:
- Tile-local transmit stage directly upstream of the switch's local input port (stream_in_local_in_*).
- Takes a message command (destination {Y,X}, payload length) plus a raw payload word stream from the accelerator.
- Emits one NoC packet on the line clock: a header word built from destination, source and length, then exactly the commanded number of payload words.
- Generates TLAST from its own word count, so the accelerator does not have to frame packets for the network.

Parameters:
- BW, 32, stream data width; must be >= 32.
- BWB, BW/8, TKEEP width.
- XY_SZ, 3, width of one mesh coordinate.
- LEN_W, 12, payload length field width; must be <= 12.
- HDR_TAG, 4'hA, constant placed in header bits [31:28].

Ports:
- clk_line  in  1  line clock; sole clock of the block.
- clk_line_rst_high  in  1  asynchronous, active-high reset.
- HsrcId  in  2*XY_SZ  this tile's {Y,X}; quasi-static.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_dst  in  2*XY_SZ  destination {Y,X}.
- cmd_len  in  LEN_W  payload words, 0..2^LEN_W-1.
- pay_TVALID  in  1  payload valid.
- pay_TDATA  in  BW  payload data.
- pay_TKEEP  in  BWB  payload byte enables.
- pay_TLAST  in  1  sender's end-of-message marker; checked only.
- pay_TREADY  out  1  payload accepted.
- out_TVALID  out  1  packet word valid (to switch local in).
- out_TDATA  out  BW  packet word.
- out_TKEEP  out  BWB  packet byte enables.
- out_TLAST  out  1  last word of packet.
- out_TREADY  in  1  switch accepts word.
- busy  out  1  high while state is PAYLOAD or out_TVALID is high.
- err_clr  in  1  synchronous clear of err_last_mismatch.
- err_last_mismatch  out  1  sticky framing error flag.
- pkt_count  out  16  packets delivered; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (asynchronous): state=IDLE; out_TVALID=0; out_TDATA, out_TKEEP, out_TLAST=0; remaining counter=0; err_last_mismatch=0; pkt_count=0.
  - Reset mid-packet drops the partial packet immediately; no TLAST is emitted for it.
- Output register: a single register drives all out_* signals.
  - adv = !out_TVALID || out_TREADY. The register loads only when adv is high.
  - When adv is high and nothing loads, out_TVALID goes to 0.
  - out_* stays stable while out_TVALID=1 and out_TREADY=0 (AXI-Stream rule).
- FSM states: IDLE and PAYLOAD.
- IDLE:
  - cmd_ready = adv. pay_TREADY = 0.
  - On cmd_valid && cmd_ready, load the header into the output register:
    - TDATA[5:0] = cmd_dst (generally [2*XY_SZ-1:0]).
    - next 2*XY_SZ bits = HsrcId.
    - bits up to [15] = 0.
    - [16+LEN_W-1:16] = cmd_len.
    - [27:16+LEN_W] = 0; [31:28] = HDR_TAG; bits above 31 = 0.
    - TKEEP = all ones.
  - If cmd_len == 0: header TLAST=1, stay in IDLE.
  - Otherwise: TLAST=0, remaining=cmd_len, go to PAYLOAD.
- Latency: the header is on out_TVALID the cycle after the command is accepted.
- PAYLOAD:
  - cmd_ready = 0. pay_TREADY = adv.
  - On pay_TVALID && pay_TREADY: load pay_TDATA and pay_TKEEP; TLAST = (remaining == 1); decrement remaining.
  - When remaining == 1, return to IDLE.
  - Throughput: one word per cycle when out_TREADY is held high.
- Back-to-back: the cycle after the last payload word loads, IDLE can accept the next command. The next header can follow the previous TLAST word with no bubble.
- Framing check, on each accepted payload word:
  - pay_TLAST=1 on a word that is not the last → set err_last_mismatch.
  - pay_TLAST=0 on the last word → set err_last_mismatch.
  - Data flow and the count are unaffected; the count always governs framing.
  - err_clr clears the flag; a set in the same cycle as err_clr wins.
- pkt_count increments on each out_TVALID && out_TREADY && out_TLAST.
- Output word TKEEP is passed through unmodified, including partial TKEEP on non-last words.
- HsrcId is sampled at command acceptance only.

Test Plan:
- Header format: HsrcId=6'h15, cmd_dst=6'h0B, cmd_len=3, out_TREADY=1, payload 0x11, 0x22, 0x33 with TLAST on 0x33 → out words 0xA003054B, 0x11, 0x22, 0x33(TLAST=1); 4 consecutive cycles; pkt_count=1; err_last_mismatch=0.
- Zero length: cmd_len=0, cmd_dst=6'h01 → single word 0xA0000541 with TLAST=1; pay_TREADY never asserts; pkt_count increments by 1.
- Backpressure: cmd_len=4, out_TREADY toggling 1,0,0,1,… → each word held stable while stalled; pay_TREADY=0 during stalls; no loss or duplication; TLAST on the 4th payload word only.
- Back-to-back: two commands (len 2, len 1) pre-queued, out_TREADY=1 → 5 output words in 5 consecutive cycles: H1, D, D(L), H2, D(L); pkt_count=2.
- Framing error: cmd_len=3, pay_TLAST=1 on the 2nd word → err_last_mismatch=1 from the next cycle; TLAST is still emitted on the 3rd word; err_clr pulse → flag returns to 0.
- Reset mid-packet: assert clk_line_rst_high after the 2nd of 5 payload words → out_TVALID=0 asynchronously and cmd_ready=1 after release; a fresh len=1 command then produces a correct 2-word packet.
